pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order pipelined CPU; replaces hard-wired 2-source/EX-MEM forwarding.
//  Tracks DEPTH post-decode stages (0=EX ... DEPTH-1=WB) as a shift register of {valid,rd,regwrite,is_load}.
//  Per source operand of the decode-stage instruction: youngest-match forward select, load-use stall plus bubble insert, IF flush on taken branch.
//  Sits beside decode; drives operand forward muxes, IF/ID enables and pipeline bubble control.
// PARAMETERS
//  NREG       32  architectural register count
//  REGW       5   register index width, $clog2(NREG)
//  NSRC       2   source operands per instruction
//  DEPTH      3   tracked stages after decode (EX, MEM, WB)
//  LOAD_STAGE 1   first stage index whose load result is forwardable
//  ZREG       31  zero register (XZR): never hazards, never forwarded
//  CNTW       16  load-use stall counter width
//  SELW       $clog2(DEPTH+1)  forward select width per source
// PORTS
//  clk          in   1            clock, rising edge
//  reset        in   1            async, active-low (0 = reset)
//  id_valid     in   1            decode stage holds a valid instruction
//  id_rd        in   REGW         decode destination register
//  id_regwrite  in   1            decode instruction writes id_rd
//  id_is_load   in   1            decode instruction is a load
//  id_src       in   NSRC*REGW    source register indices, src s at [s*REGW +: REGW]
//  id_src_used  in   NSRC         source s is actually read
//  br_taken     in   1            branch unit: IF instruction is wrong-path
//  ext_stall    in   1            freeze whole pipeline (memory wait)
//  stall        out  1            hold PC and IF/ID register
//  flush_if     out  1            squash IF/ID contents
//  fwd_sel      out  NSRC*SELW    0=regfile, k+1=result of stage k
//  st_valid     out  DEPTH        per-stage valid
//  st_rd        out  DEPTH*REGW   per-stage destination
//  st_regwrite  out  DEPTH        per-stage regwrite
//  load_use_cnt out  CNTW         load-use stall cycle count
// BEHAVIOUR
//  Reset (reset=0, async): all stage valid/regwrite/is_load=0, rd=0, load_use_cnt=0. Hence stall=ext_stall, fwd_sel=0.
//  Match(s,k): st_valid[k] & st_regwrite[k] & st_rd[k]==src_s & id_src_used[s] & src_s!=ZREG & id_valid.
//  For each source, km = smallest k with Match. None -> fwd_sel=0.
//  km found and (!is_load[km] | km>=LOAD_STAGE) -> fwd_sel=km+1.
//  km found, is_load[km], km<LOAD_STAGE -> lu(s)=1, fwd_sel=0. The youngest match decides; older matches are ignored.
//  load_use = OR over s of lu(s). stall = load_use | ext_stall. flush_if = br_taken & ~stall.
//  All select/stall outputs are combinational from state and id_* inputs; zero-cycle latency.
//  Clocked update, ext_stall=1: every stage register holds; counter holds.
//  Clocked update, ext_stall=0: stage[k+1] <= stage[k]; the WB entry drops off.
//  stage[0] <= {id_valid,id_rd,id_regwrite,id_is_load} when ~load_use, else bubble (all zero).
//  br_taken never bubbles stage[0]: the branch in decode proceeds (BL writes X30).
//  load_use_cnt += 1 on each cycle with load_use & ~ext_stall; saturates at 2^CNTW-1, no wrap.
//  Same-cycle WB write/decode read is covered by forwarding from stage DEPTH-1; the regfile needs no write-through.
//  id_valid=0 forces all fwd_sel=0 and load_use=0.
//  Reset asserted mid-operation clears state immediately; the first post-reset cycle behaves as empty pipe.
// TESTING
//  1. Reset, insert ADD X1 (rd=1,rw=1), then consumer src0=X1 at 1/2/3/4 cycles later -> fwd_sel[0]=1,2,3, then 0.
//  2. LDUR X2 then immediate consumer src1=X2 -> stall=1 one cycle, stage0 bubble, st_valid=3'b010; next cycle fwd_sel[1]=2, load_use_cnt=1.
//  3. Writers of X3 in stages 0 and 2, consumer src0=X3 -> fwd_sel[0]=1. Load to X3 in stage0 plus ALU X3 in stage1 -> stall=1.
//  4. Writer rd=31 in stage0, consumer src0=X31 -> fwd_sel[0]=0, stall=0. id_src_used=0 with matching rd -> fwd_sel=0.
//  5. br_taken=1 with no hazard -> flush_if=1. br_taken=1 during load-use stall or ext_stall -> flush_if=0.
//  6. ext_stall=1 for 3 cycles -> st_* unchanged, counter unchanged. CNTW=2 with 5 load-use cycles -> load_use_cnt=3. reset=0 mid-run -> st_valid=0 before next edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Parametrised hazard / forwarding controller. Tracks DEPTH
//                post-decode stages, picks the youngest forwarding source for
//                each decode operand, raises load-use stalls with bubble
//                insertion and squashes IF on a taken branch.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int NREG       = 32,
  parameter int REGW       = $clog2(NREG),
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int ZREG       = 31,
  parameter int CNTW       = 16,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   id_valid_i,
  input  logic [REGW-1:0]        id_rd_i,
  input  logic                   id_regwrite_i,
  input  logic                   id_is_load_i,
  input  logic [NSRC*REGW-1:0]   id_src_i,
  input  logic [NSRC-1:0]        id_src_used_i,
  input  logic                   br_taken_i,
  input  logic                   ext_stall_i,
  output logic                   stall_o,
  output logic                   flush_if_o,
  output logic [NSRC*SELW-1:0]   fwd_sel_o,
  output logic [DEPTH-1:0]       st_valid_o,
  output logic [DEPTH*REGW-1:0]  st_rd_o,
  output logic [DEPTH-1:0]       st_regwrite_o,
  output logic [CNTW-1:0]        load_use_cnt_o
);

  localparam logic [REGW-1:0] ZREG_IDX = REGW'(ZREG);

  // Stage tracking registers: index 0 = EX, DEPTH-1 = WB
  logic [DEPTH-1:0]           st_valid_q, st_valid_d;
  logic [DEPTH-1:0][REGW-1:0] st_rd_q, st_rd_d;
  logic [DEPTH-1:0]           st_regwrite_q, st_regwrite_d;
  logic [DEPTH-1:0]           st_is_load_q, st_is_load_d;
  logic [CNTW-1:0]            cnt_q, cnt_d;

  logic [NSRC-1:0]            lu_w;
  logic                       load_use_w;

  // Per-operand hazard detection and forward selection
  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      logic [REGW-1:0]  src_w;
      logic [DEPTH-1:0] match_w;
      logic             lu_s_w;
      logic [SELW-1:0]  sel_s_w;

      assign src_w = id_src_i[s*REGW +: REGW];

      for (genvar k = 0; k < DEPTH; k++) begin : g_match
        assign match_w[k] = id_valid_i & id_src_used_i[s] & (src_w != ZREG_IDX) &
                            st_valid_q[k] & st_regwrite_q[k] & (st_rd_q[k] == src_w);
      end

      // Scan oldest to youngest so the youngest matching stage wins
      always_comb begin
        lu_s_w  = 1'b0;
        sel_s_w = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (match_w[k]) begin
            if (st_is_load_q[k] && (k < LOAD_STAGE)) begin
              lu_s_w  = 1'b1;
              sel_s_w = '0;
            end else begin
              lu_s_w  = 1'b0;
              sel_s_w = SELW'(k + 1);
            end
          end
        end
      end

      assign lu_w[s]                   = lu_s_w;
      assign fwd_sel_o[s*SELW +: SELW] = sel_s_w;
    end
  endgenerate

  assign load_use_w = |lu_w;
  assign stall_o    = load_use_w | ext_stall_i;
  assign flush_if_o = br_taken_i & ~stall_o;

  // Next state: advance the stage shift register unless externally frozen
  always_comb begin
    st_valid_d    = st_valid_q;
    st_rd_d       = st_rd_q;
    st_regwrite_d = st_regwrite_q;
    st_is_load_d  = st_is_load_q;
    cnt_d         = cnt_q;
    if (!ext_stall_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        st_valid_d[k]    = st_valid_q[k-1];
        st_rd_d[k]       = st_rd_q[k-1];
        st_regwrite_d[k] = st_regwrite_q[k-1];
        st_is_load_d[k]  = st_is_load_q[k-1];
      end
      if (load_use_w) begin
        st_valid_d[0]    = 1'b0;
        st_rd_d[0]       = '0;
        st_regwrite_d[0] = 1'b0;
        st_is_load_d[0]  = 1'b0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        st_valid_d[0]    = id_valid_i;
        st_rd_d[0]       = id_rd_i;
        st_regwrite_d[0] = id_regwrite_i;
        st_is_load_d[0]  = id_is_load_i;
      end
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      st_valid_q    <= '0;
      st_rd_q       <= '0;
      st_regwrite_q <= '0;
      st_is_load_q  <= '0;
      cnt_q         <= '0;
    end else begin
      st_valid_q    <= st_valid_d;
      st_rd_q       <= st_rd_d;
      st_regwrite_q <= st_regwrite_d;
      st_is_load_q  <= st_is_load_d;
      cnt_q         <= cnt_d;
    end
  end

  assign st_valid_o     = st_valid_q;
  assign st_rd_o        = st_rd_q;
  assign st_regwrite_o  = st_regwrite_q;
  assign load_use_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl (default build plus a
//                narrow-counter build sharing the same stimulus).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_is_load;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        br_taken;
  logic        ext_stall;

  logic        stall, flush_if;
  logic [3:0]  fwd_sel;
  logic [2:0]  st_valid, st_regwrite;
  logic [14:0] st_rd;
  logic [15:0] lu_cnt;

  logic        stall_b, flush_b;
  logic [3:0]  fwd_b;
  logic [2:0]  stv_b, strw_b;
  logic [14:0] strd_b;
  logic [1:0]  lu_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic        stall;
    logic        flush;
    logic [1:0]  f0;
    logic [1:0]  f1;
    logic [2:0]  stv;
    int          cnt;
    int          cntb;
  } exp_t;

  exp_t sb_q[$];

  pipe_hazard_ctrl dut (
    .clk_i(clk), .reset_ni(rst_n), .id_valid_i(id_valid), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load), .id_src_i(id_src),
    .id_src_used_i(id_src_used), .br_taken_i(br_taken), .ext_stall_i(ext_stall),
    .stall_o(stall), .flush_if_o(flush_if), .fwd_sel_o(fwd_sel),
    .st_valid_o(st_valid), .st_rd_o(st_rd), .st_regwrite_o(st_regwrite),
    .load_use_cnt_o(lu_cnt)
  );

  pipe_hazard_ctrl #(.CNTW(2)) dut_b (
    .clk_i(clk), .reset_ni(rst_n), .id_valid_i(id_valid), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_is_load_i(id_is_load), .id_src_i(id_src),
    .id_src_used_i(id_src_used), .br_taken_i(br_taken), .ext_stall_i(ext_stall),
    .stall_o(stall_b), .flush_if_o(flush_b), .fwd_sel_o(fwd_b),
    .st_valid_o(stv_b), .st_rd_o(strd_b), .st_regwrite_o(strw_b),
    .load_use_cnt_o(lu_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                       input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                       input logic br, input logic es);
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    id_src      = {s1, s0};
    id_src_used = used;
    br_taken    = br;
    ext_stall   = es;
  endtask

  // Push the expectation, let outputs settle, then pop and compare
  task automatic expect_now(input string tag, input logic e_stall, input logic e_flush,
                            input logic [1:0] e_f0, input logic [1:0] e_f1,
                            input logic [2:0] e_stv, input int e_cnt);
    exp_t e;
    e.tag = tag; e.stall = e_stall; e.flush = e_flush; e.f0 = e_f0; e.f1 = e_f1;
    e.stv = e_stv; e.cnt = e_cnt; e.cntb = (e_cnt > 3) ? 3 : e_cnt;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
      chk({e.tag, ".flush"}, 32'(flush_if), 32'(e.flush));
      chk({e.tag, ".fwd0"}, 32'(fwd_sel[1:0]), 32'(e.f0));
      chk({e.tag, ".fwd1"}, 32'(fwd_sel[3:2]), 32'(e.f1));
      chk({e.tag, ".st_valid"}, 32'(st_valid), 32'(e.stv));
      chk({e.tag, ".cnt"}, 32'(lu_cnt), 32'(e.cnt));
      chk({e.tag, ".cnt_sat"}, 32'(lu_cnt_b), 32'(e.cntb));
    end
  endtask

  task automatic step(input string tag,
                      input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                      input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                      input logic br, input logic es,
                      input logic e_stall, input logic e_flush, input logic [1:0] e_f0,
                      input logic [1:0] e_f1, input logic [2:0] e_stv, input int e_cnt);
    @(negedge clk);
    drive(v, rd, rw, ld, s0, s1, used, br, es);
    expect_now(tag, e_stall, e_flush, e_f0, e_f1, e_stv, e_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    //   tag        v rd rw ld s0 s1 used  br es | stl fl f0 f1 stv    cnt
    step("rst_es",   0, 0, 0, 0, 0, 0, 2'b00, 0, 1,  1, 0, 0, 0, 3'b000, 0);
    step("rst",      0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Forward distance 1/2/3/4 from ADD X1
    step("add_x1",   1, 1, 1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b000, 0);
    step("fwd_d1",   1,10, 0, 0, 1, 0, 2'b01, 0, 0,  0, 0, 1, 0, 3'b001, 0);
    step("fwd_d2",   1,10, 0, 0, 1, 0, 2'b01, 0, 0,  0, 0, 2, 0, 3'b011, 0);
    step("fwd_d3",   1,10, 0, 0, 1, 0, 2'b01, 0, 0,  0, 0, 3, 0, 3'b111, 0);
    step("fwd_d4",   1,10, 0, 0, 1, 0, 2'b01, 0, 0,  0, 0, 0, 0, 3'b111, 0);
    step("idle1",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b111, 0);
    step("idle2",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b110, 0);
    step("idle3",    0, 0, 0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b100, 0);
    // Load-use on src1
    step("ldur_x2",  1, 2, 1, 1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b000, 0);
    step("lu_stall", 1,11, 0, 0, 0, 2, 2'b10, 0, 0,  1, 0, 0, 0, 3'b001, 0);
    step("lu_after", 1,11, 0, 0, 0, 2, 2'b10, 0, 0,  0, 0, 0, 2, 3'b010, 1);
    // Youngest match wins
    step("alu_x3a",  1, 3, 1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b101, 1);
    step("filler",   1, 8, 0, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b011, 1);
    step("alu_x3b",  1, 3, 1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b111, 1);
    step("young",    1, 9, 0, 0, 3, 3, 2'b11, 0, 0,  0, 0, 1, 1, 3'b111, 1);
    step("alu_x3c",  1, 3, 1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b111, 1);
    step("ld_x3",    1, 3, 1, 1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b111, 1);
    step("young_lu", 1, 9, 0, 0, 3, 0, 2'b01, 0, 0,  1, 0, 0, 0, 3'b111, 1);
    step("young_ld", 1, 9, 0, 0, 3, 0, 2'b01, 0, 0,  0, 0, 2, 0, 3'b110, 2);
    // Zero register and unused sources
    step("alu_x31",  1,31, 1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b101, 2);
    step("zreg",     1, 9, 0, 0,31,31, 2'b11, 0, 0,  0, 0, 0, 0, 3'b011, 2);
    step("alu_x4",   1, 4, 1, 0, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b111, 2);
    step("unused",   1, 9, 0, 0, 4, 4, 2'b10, 0, 0,  0, 0, 0, 1, 3'b111, 2);
    step("id_inval", 0, 0, 0, 0, 4, 0, 2'b01, 0, 0,  0, 0, 0, 0, 3'b111, 2);
    // Branch flush
    step("br_flush", 1, 9, 0, 0, 0, 0, 2'b00, 1, 0,  0, 1, 0, 0, 3'b110, 2);
    step("ld_x5",    1, 5, 1, 1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b101, 2);
    step("br_lu",    1, 9, 0, 0, 5, 0, 2'b01, 1, 0,  1, 0, 0, 0, 3'b011, 2);
    step("br_lu2",   1, 9, 0, 0, 5, 0, 2'b01, 0, 0,  0, 0, 2, 0, 3'b110, 3);
    // External stall freezes the pipe
    step("es1",      1, 9, 0, 0, 5, 0, 2'b01, 1, 1,  1, 0, 3, 0, 3'b101, 3);
    step("es2",      1, 9, 0, 0, 5, 0, 2'b01, 1, 1,  1, 0, 3, 0, 3'b101, 3);
    step("es3",      1, 9, 0, 0, 5, 0, 2'b01, 1, 1,  1, 0, 3, 0, 3'b101, 3);
    step("es_rel",   1, 9, 0, 0, 5, 0, 2'b01, 0, 0,  0, 0, 3, 0, 3'b101, 3);
    step("ld_x6",    1, 6, 1, 1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b011, 3);
    step("es_lu",    1, 9, 0, 0, 6, 0, 2'b01, 0, 1,  1, 0, 0, 0, 3'b111, 3);
    step("lu_x6",    1, 9, 0, 0, 6, 0, 2'b01, 0, 0,  1, 0, 0, 0, 3'b111, 3);
    step("lu_x6b",   1, 9, 0, 0, 6, 0, 2'b01, 0, 0,  0, 0, 2, 0, 3'b110, 4);
    step("ld_x7",    1, 7, 1, 1, 0, 0, 2'b00, 0, 0,  0, 0, 0, 0, 3'b101, 4);
    step("lu_x7",    1, 9, 0, 0, 0, 7, 2'b10, 0, 0,  1, 0, 0, 0, 3'b011, 4);
    step("lu_x7b",   1, 9, 0, 0, 0, 7, 2'b10, 0, 0,  0, 0, 0, 2, 3'b110, 5);
    // Asynchronous reset mid-run, then empty-pipe behaviour
    #2;
    rst_n = 1'b0;
    expect_now("mid_rst",                              0, 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 1, 0, 7, 0, 2'b01, 0, 0);
    expect_now("post_rst",                             0, 0, 0, 0, 3'b000, 0);
    step("post_fwd", 1, 9, 0, 0, 1, 0, 2'b01, 0, 0,  0, 0, 1, 0, 3'b001, 0);

    if (sb_q.size() != 0) chk("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
